conv_accum_relu_lane: RTL and testbench
=======================================

Name: conv_accum_relu_lane

Overview:
- One output-channel lane of the CNN accelerator datapath.
- A 3x3 signed-weight convolution core feeds a per-pixel partial-sum accumulator RAM. The RAM is read back through a shift-and-ReLU saturating stage.
- Sits between the sliding window / weight registers and the max-pooling engine. The accelerator instantiates 16 lanes sharing window, address and control.

Parameters:
- ADDR_W, 12, accumulator address width.
- DEPTH, 4096, accumulator entries (one per output pixel of the largest layer).
- CONV_W, 20, signed convolution result width.
- ACC_W, 24, signed accumulator word width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- window_valid  in  1  sliding-window contents valid
- fsm_window_valid  in  1  sequencer pixel-stream valid (qualifies window_valid)
- x  in  11  window column coordinate
- y  in  10  window row coordinate
- w00..w22  in  8 each  nine window pixels, unsigned
- K00..K22  in  8 each  nine kernel weights, signed two's complement
- conv_out  out  20  signed convolution result
- conv_valid  out  1  conv_out valid
- x_out  out  11  x delayed to align with conv_out
- y_out  out  10  y delayed to align with conv_out
- addr  in  12  accumulator address (shared by read and write)
- write_en  in  1  write conv_out into accumulator
- ow_add  in  1  1 = overwrite, 0 = add to stored value
- read_en  in  1  read accumulator
- relu_shift  in  5  arithmetic right shift applied before ReLU
- acc_out  out  24  signed accumulator read data
- acc_valid  out  1  acc_out valid
- relu_out  out  8  saturated ReLU of (acc_out >>> relu_shift)

Behaviour:
- Reset (reset=0, async) clears conv_out, conv_valid, x_out, y_out, acc_out and acc_valid to 0.
- Accumulator RAM contents are not cleared by reset. The first channel pass must use ow_add=1.
- Convolution products:
  - Each pixel is zero-extended to 9-bit signed and multiplied by its signed weight, giving 17-bit signed products.
  - The nine products are summed sign-extended to 20 bits. Worst case ±293760 fits, so no overflow handling is needed.
- Convolution pipeline is 2 stages:
  - Stage 1 registers the 9 products plus qualifier and coordinates on edges where window_valid && fsm_window_valid.
  - Stage 2 registers the sum.
  - conv_valid pulses 2 cycles after a qualified window, once per qualified cycle. Back-to-back windows give back-to-back results.
  - When unqualified, conv_valid=0 and conv_out holds its last value.
- Weights are sampled in stage 1 at the same edge as the pixels.
- Accumulator write, at a clock edge with write_en=1:
  - If ow_add=1: mem[addr] <= sign-extended conv_out.
  - If ow_add=0: mem[addr] <= mem[addr] + sign-extended conv_out, with two's-complement 24-bit wrap.
- The write uses the conv_out value present at that edge. The sequencer aligns write_en with conv_valid.
- Accumulator read:
  - An edge with read_en=1 registers mem[addr] into acc_out and sets acc_valid=1, giving 1-cycle latency.
  - With read_en=0, acc_valid=0 and acc_out holds.
- Simultaneous read_en and write_en to the same address returns the old (pre-write) value.
- addr values at or above DEPTH are ignored on write and return 0 on read.
- ReLU (combinational from acc_out):
  - Compute s = acc_out >>> relu_shift (arithmetic).
  - s<0 gives 0; s>255 gives 255; otherwise relu_out = s[7:0].
  - relu_shift 0..23 is meaningful; values above 23 yield 0 or all-ones-shift (i.e. 0 for negative inputs).

Test Plan:
- Assert reset mid-stream with conv_valid=1 and acc_valid=1 -> all outputs 0 immediately, no clock needed.
- All pixels 10, all weights +1, one qualified cycle -> conv_valid pulses exactly 2 cycles later with conv_out=90. With fsm_window_valid=0 and window_valid=1 there is no pulse.
- All pixels 255, all weights -128 -> conv_out = -293760. Mixed case: w11=200, K11=-3, all others 0 -> conv_out = -600.
- Accumulate:
  - write addr 5 with ow_add=1 and conv_out=90;
  - then write addr 5 with ow_add=0 and conv_out=-600;
  - then read addr 5 -> acc_out=-510 one cycle after read_en, acc_valid=1 for one cycle, relu_out=0.
- ReLU saturation:
  - acc 1000 with shift 0 -> 255;
  - shift 2 -> 250;
  - acc 300 with shift 1 -> 150;
  - acc -1 with shift 5 -> 0.
- Read and write addr 7 in the same cycle (old value 40, write ow_add=1 with 90) -> read returns 40; a following read returns 90.

Source files
------------

// File: rtl/conv_accum_relu_lane.sv
`default_nettype none
// ============================================================================
// Module      : conv_accum_relu_lane
// Description : One output-channel lane of the CNN datapath. A 3x3
//               unsigned-pixel x signed-weight convolution (2-stage pipe)
//               feeds a per-pixel partial-sum accumulator RAM, which is read
//               back through an arithmetic-shift + saturating ReLU stage.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_accum_relu_lane #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int CONV_W = 20,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              window_valid,
    input  logic              fsm_window_valid,
    input  logic [10:0]       x,
    input  logic [9:0]        y,
    input  logic [7:0]        w00,
    input  logic [7:0]        w01,
    input  logic [7:0]        w02,
    input  logic [7:0]        w10,
    input  logic [7:0]        w11,
    input  logic [7:0]        w12,
    input  logic [7:0]        w20,
    input  logic [7:0]        w21,
    input  logic [7:0]        w22,
    input  logic [7:0]        K00,
    input  logic [7:0]        K01,
    input  logic [7:0]        K02,
    input  logic [7:0]        K10,
    input  logic [7:0]        K11,
    input  logic [7:0]        K12,
    input  logic [7:0]        K20,
    input  logic [7:0]        K21,
    input  logic [7:0]        K22,
    output logic [CONV_W-1:0] conv_out,
    output logic              conv_valid,
    output logic [10:0]       x_out,
    output logic [9:0]        y_out,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write_en,
    input  logic              ow_add,
    input  logic              read_en,
    input  logic [4:0]        relu_shift,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic [7:0]        relu_out
);

    // 9-bit signed pixel x 8-bit signed weight
    localparam int c_PROD_W = 17;
    localparam int c_NTAPS  = 9;
    localparam int c_SUM_EXT = CONV_W - c_PROD_W;
    localparam int c_ACC_EXT = ACC_W - CONV_W;

    logic        [7:0]          w_pix  [c_NTAPS];
    logic signed [7:0]          w_k    [c_NTAPS];
    logic signed [c_PROD_W-1:0] w_prod [c_NTAPS];
    logic signed [c_PROD_W-1:0] r_prod [c_NTAPS];
    logic                       w_qual;
    logic                       r_s1_valid;
    logic [10:0]                r_s1_x;
    logic [9:0]                 r_s1_y;
    logic [CONV_W-1:0]          w_sum;
    logic [CONV_W-1:0]          r_conv_out;
    logic                       r_conv_valid;
    logic [10:0]                r_x_out;
    logic [9:0]                 r_y_out;
    logic [ACC_W-1:0]           r_mem [DEPTH];
    logic [ACC_W-1:0]           w_conv_ext;
    logic                       w_addr_ok;
    logic [ACC_W-1:0]           r_acc_out;
    logic                       r_acc_valid;
    logic signed [ACC_W-1:0]    w_shifted;
    logic [7:0]                 w_relu;

    assign w_pix[0] = w00;  assign w_k[0] = K00;
    assign w_pix[1] = w01;  assign w_k[1] = K01;
    assign w_pix[2] = w02;  assign w_k[2] = K02;
    assign w_pix[3] = w10;  assign w_k[3] = K10;
    assign w_pix[4] = w11;  assign w_k[4] = K11;
    assign w_pix[5] = w12;  assign w_k[5] = K12;
    assign w_pix[6] = w20;  assign w_k[6] = K20;
    assign w_pix[7] = w21;  assign w_k[7] = K21;
    assign w_pix[8] = w22;  assign w_k[8] = K22;

    assign w_qual = window_valid && fsm_window_valid;

    // Pixels are unsigned, so a zero bit on top makes them non-negative signed
    generate
        for (genvar gi = 0; gi < c_NTAPS; gi++) begin : g_prod
            assign w_prod[gi] = $signed({1'b0, w_pix[gi]}) * w_k[gi];
        end
    endgenerate

    // Stage 1: capture products and coordinates of a qualified window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            for (int i = 0; i < c_NTAPS; i++) r_prod[i] <= '0;
        end else begin
            r_s1_valid <= w_qual;
            if (w_qual) begin
                r_s1_x <= x;
                r_s1_y <= y;
                for (int i = 0; i < c_NTAPS; i++) r_prod[i] <= w_prod[i];
            end
        end
    end

    // Adder tree over sign-extended products; worst case fits CONV_W bits
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_NTAPS; i++) begin
            w_sum = w_sum + {{c_SUM_EXT{r_prod[i][c_PROD_W-1]}}, r_prod[i]};
        end
    end

    // Stage 2: register the sum; outputs hold between valid pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_conv_out   <= '0;
            r_conv_valid <= 1'b0;
            r_x_out      <= '0;
            r_y_out      <= '0;
        end else begin
            r_conv_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_conv_out <= w_sum;
                r_x_out    <= r_s1_x;
                r_y_out    <= r_s1_y;
            end
        end
    end

    assign conv_out   = r_conv_out;
    assign conv_valid = r_conv_valid;
    assign x_out      = r_x_out;
    assign y_out      = r_y_out;

    // Only compare against DEPTH when the address space exceeds it
    generate
        if (DEPTH >= (2 ** ADDR_W)) begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end else begin : g_addr_partial
            assign w_addr_ok = (int'(addr) < DEPTH);
        end
    endgenerate

    assign w_conv_ext = {{c_ACC_EXT{r_conv_out[CONV_W-1]}}, r_conv_out};

    // Accumulator RAM: overwrite or read-modify-write add; no reset on contents
    always_ff @(posedge clk) begin
        if (write_en && w_addr_ok) begin
            if (ow_add) begin
                r_mem[addr] <= w_conv_ext;
            end else begin
                r_mem[addr] <= r_mem[addr] + w_conv_ext;
            end
        end
    end

    // Read port: same-edge write is not visible, so the old value is returned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_out   <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= read_en;
            if (read_en) begin
                r_acc_out <= w_addr_ok ? r_mem[addr] : '0;
            end
        end
    end

    assign acc_out   = r_acc_out;
    assign acc_valid = r_acc_valid;

    // Shift then clamp to [0, 255]; large shifts collapse to the sign
    always_comb begin
        w_shifted = $signed(r_acc_out) >>> relu_shift;
        if (w_shifted[ACC_W-1]) begin
            w_relu = 8'd0;
        end else if (|w_shifted[ACC_W-2:8]) begin
            w_relu = 8'd255;
        end else begin
            w_relu = w_shifted[7:0];
        end
    end

    assign relu_out = w_relu;

endmodule
`default_nettype wire

// File: tb/tb_conv_accum_relu_lane.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_accum_relu_lane
// Description : Scoreboard bench for conv_accum_relu_lane. Expected
//               convolution and accumulator read results are queued with the
//               cycle they are due and compared when the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_accum_relu_lane;

    logic        clk = 1'b0;
    logic        reset;
    logic        window_valid;
    logic        fsm_window_valid;
    logic [10:0] x;
    logic [9:0]  y;
    logic [7:0]        pix [9];
    logic signed [7:0] kw  [9];
    logic [19:0] conv_out;
    logic        conv_valid;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [11:0] addr;
    logic        write_en;
    logic        ow_add;
    logic        read_en;
    logic [4:0]  relu_shift;
    logic [23:0] acc_out;
    logic        acc_valid;
    logic [7:0]  relu_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    longint last_conv = 0;
    longint model_mem [int];

    typedef struct {
        longint val;
        int     xx;
        int     yy;
        int     due;
    } conv_exp_t;

    typedef struct {
        longint acc;
        int     relu;
        int     due;
    } acc_exp_t;

    conv_exp_t conv_q [$];
    acc_exp_t  acc_q  [$];

    conv_accum_relu_lane dut (
        .clk              (clk),
        .reset            (reset),
        .window_valid     (window_valid),
        .fsm_window_valid (fsm_window_valid),
        .x                (x),
        .y                (y),
        .w00 (pix[0]), .w01 (pix[1]), .w02 (pix[2]),
        .w10 (pix[3]), .w11 (pix[4]), .w12 (pix[5]),
        .w20 (pix[6]), .w21 (pix[7]), .w22 (pix[8]),
        .K00 (kw[0]),  .K01 (kw[1]),  .K02 (kw[2]),
        .K10 (kw[3]),  .K11 (kw[4]),  .K12 (kw[5]),
        .K20 (kw[6]),  .K21 (kw[7]),  .K22 (kw[8]),
        .conv_out         (conv_out),
        .conv_valid       (conv_valid),
        .x_out            (x_out),
        .y_out            (y_out),
        .addr             (addr),
        .write_en         (write_en),
        .ow_add           (ow_add),
        .read_en          (read_en),
        .relu_shift       (relu_shift),
        .acc_out          (acc_out),
        .acc_valid        (acc_valid),
        .relu_out         (relu_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint conv_model();
        longint s = 0;
        for (int i = 0; i < 9; i++) s += longint'(pix[i]) * longint'(kw[i]);
        return s;
    endfunction

    function automatic int relu_model(input longint acc, input int sh);
        longint s = acc >>> sh;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return int'(s);
    endfunction

    function automatic longint wrap24(input longint v);
        logic signed [23:0] t = v[23:0];
        return longint'(t);
    endfunction

    // Compare queued expectations against DUT outputs, away from the active edge
    always @(negedge clk) begin
        if (conv_q.size() > 0 && conv_q[0].due == cyc) begin
            check_val("conv_valid", longint'(conv_valid), 1);
            check_val("conv_out", longint'($signed(conv_out)), conv_q[0].val);
            check_val("x_out", longint'(x_out), longint'(conv_q[0].xx));
            check_val("y_out", longint'(y_out), longint'(conv_q[0].yy));
            void'(conv_q.pop_front());
        end else if (conv_valid) begin
            check_val("conv_valid_spurious", longint'(conv_valid), 0);
        end
        if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
            check_val("acc_valid", longint'(acc_valid), 1);
            check_val("acc_out", longint'($signed(acc_out)), acc_q[0].acc);
            check_val("relu_out", longint'(relu_out), longint'(acc_q[0].relu));
            void'(acc_q.pop_front());
        end else if (acc_valid) begin
            check_val("acc_valid_spurious", longint'(acc_valid), 0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_window(input int p, input int k);
        for (int i = 0; i < 9; i++) begin
            pix[i] = 8'(p);
            kw[i]  = 8'(k);
        end
    endtask

    // Present one qualified window this cycle and queue its result
    task automatic push_window(input int xx, input int yy);
        conv_exp_t e;
        window_valid     = 1'b1;
        fsm_window_valid = 1'b1;
        x = 11'(xx);
        y = 10'(yy);
        e.val = conv_model();
        e.xx  = xx;
        e.yy  = yy;
        e.due = cyc + 2;
        last_conv = e.val;
        conv_q.push_back(e);
    endtask

    task automatic idle(input int n);
        window_valid     = 1'b0;
        fsm_window_valid = 1'b0;
        write_en         = 1'b0;
        read_en          = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic conv_once(input int xx, input int yy);
        push_window(xx, yy);
        next_cycle();
        idle(3);
    endtask

    task automatic acc_write(input int a, input logic ow);
        addr     = 12'(a);
        write_en = 1'b1;
        ow_add   = ow;
        if (ow) model_mem[a] = last_conv;
        else    model_mem[a] = wrap24(model_mem[a] + last_conv);
        next_cycle();
        write_en = 1'b0;
    endtask

    task automatic acc_read(input int a, input int sh);
        acc_exp_t e;
        addr       = 12'(a);
        read_en    = 1'b1;
        relu_shift = 5'(sh);
        e.acc  = model_mem[a];
        e.relu = relu_model(e.acc, sh);
        e.due  = cyc + 1;
        acc_q.push_back(e);
        next_cycle();
        read_en = 1'b0;
        next_cycle();
    endtask

    initial begin
        acc_exp_t ae;
        int budget;
        reset = 1'b0;
        window_valid = 1'b0;
        fsm_window_valid = 1'b0;
        x = '0;
        y = '0;
        addr = '0;
        write_en = 1'b0;
        ow_add = 1'b0;
        read_en = 1'b0;
        relu_shift = '0;
        set_window(0, 0);
        #2;
        check_val("rst_conv_out", longint'(conv_out), 0);
        check_val("rst_conv_valid", longint'(conv_valid), 0);
        check_val("rst_acc_out", longint'(acc_out), 0);
        check_val("rst_acc_valid", longint'(acc_valid), 0);
        check_val("rst_x_out", longint'(x_out), 0);
        check_val("rst_y_out", longint'(y_out), 0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Basic sum, then unqualified windows must not pulse
        set_window(10, 1);
        conv_once(3, 4);
        set_window(77, -5);
        window_valid = 1'b1;
        fsm_window_valid = 1'b0;
        x = 11'd100;
        y = 10'd200;
        repeat (4) next_cycle();
        window_valid = 1'b0;
        check_val("hold_conv_out", longint'($signed(conv_out)), 90);
        check_val("hold_x_out", longint'(x_out), 3);

        // Extreme negative
        set_window(255, -128);
        conv_once(2047, 1023);

        // Back-to-back windows
        set_window(1, 1);
        push_window(10, 11);
        next_cycle();
        set_window(2, -1);
        push_window(12, 13);
        next_cycle();
        idle(3);

        // Accumulate 90 then -600 into addr 5
        set_window(10, 1);
        conv_once(0, 0);
        acc_write(5, 1'b1);
        set_window(0, 0);
        pix[4] = 8'd200;
        kw[4]  = -8'sd3;
        conv_once(1, 1);
        acc_write(5, 1'b0);
        acc_read(5, 0);
        acc_read(5, 30);

        // ReLU saturation and shifts
        set_window(0, 0);
        pix[0] = 8'd250; kw[0] = 8'sd4;
        conv_once(0, 0);
        acc_write(10, 1'b1);
        pix[0] = 8'd150; kw[0] = 8'sd2;
        conv_once(0, 0);
        acc_write(11, 1'b1);
        pix[0] = 8'd1; kw[0] = -8'sd1;
        conv_once(0, 0);
        acc_write(12, 1'b1);
        acc_read(10, 0);
        acc_read(10, 2);
        acc_read(11, 1);
        acc_read(12, 5);
        acc_read(10, 30);

        // Same-cycle read and write to addr 7 returns the old value
        pix[0] = 8'd40; kw[0] = 8'sd1;
        conv_once(0, 0);
        acc_write(7, 1'b1);
        set_window(10, 1);
        conv_once(0, 0);
        addr = 12'd7;
        read_en = 1'b1;
        write_en = 1'b1;
        ow_add = 1'b1;
        relu_shift = 5'd0;
        ae.acc = model_mem[7];
        ae.relu = relu_model(ae.acc, 0);
        ae.due = cyc + 1;
        acc_q.push_back(ae);
        model_mem[7] = last_conv;
        next_cycle();
        read_en = 1'b0;
        write_en = 1'b0;
        next_cycle();
        acc_read(7, 0);

        // Asynchronous reset while both valids are high
        set_window(3, 1);
        push_window(5, 6);
        next_cycle();
        window_valid = 1'b0;
        fsm_window_valid = 1'b0;
        addr = 12'd5;
        read_en = 1'b1;
        relu_shift = 5'd0;
        ae.acc = model_mem[5];
        ae.relu = relu_model(ae.acc, 0);
        ae.due = cyc + 1;
        acc_q.push_back(ae);
        next_cycle();
        read_en = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_conv_out", longint'(conv_out), 0);
        check_val("arst_conv_valid", longint'(conv_valid), 0);
        check_val("arst_x_out", longint'(x_out), 0);
        check_val("arst_y_out", longint'(y_out), 0);
        check_val("arst_acc_out", longint'(acc_out), 0);
        check_val("arst_acc_valid", longint'(acc_valid), 0);
        check_val("arst_relu_out", longint'(relu_out), 0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        acc_read(5, 0);

        budget = 20;
        while ((conv_q.size() > 0 || acc_q.size() > 0) && budget > 0) begin
            next_cycle();
            budget--;
        end
        check_val("conv_q_drained", longint'(conv_q.size()), 0);
        check_val("acc_q_drained", longint'(acc_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
